// File: rtl/pixel_stream_gen.sv
// Pixel-coordinate generator for the ray-core dispatch path.
//
// Emits (pixel_x, pixel_y) beats over a valid/ready handshake for a runtime-sized
// frame in raster or tiled order, single-shot or continuous. Frame dimensions and
// mode are latched when a frame sequence starts.
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   cfg_width/cfg_height         frame size in pixels (latched on start)
//   cfg_tiled, cfg_continuous    traversal order / auto-restart (latched on start)
//   start, abort                 begin a sequence (idle only) / stop immediately
//   out_ready, out_valid         handshake towards the ray cores
//   pixel_x, pixel_y             current coordinate
//   sof, eol, eof                first pixel of frame / last of (tile) row / last of frame
//   busy, done                   generating / one-cycle pulse after single-shot frame
//   frame_cnt                    completed frames since reset (wraps)
module pixel_stream_gen #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned TILE_W  = 8,
  parameter int unsigned TILE_H  = 8,
  parameter int unsigned FCNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  input  logic               cfg_tiled,
  input  logic               cfg_continuous,
  input  logic               start,
  input  logic               abort,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  output logic               busy,
  output logic               done,
  output logic [FCNT_W-1:0]  frame_cnt
);

  localparam int unsigned CW1 = COORD_W + 1;
  localparam logic [COORD_W:0]   TileWM1   = CW1'(TILE_W - 1);
  localparam logic [COORD_W:0]   TileHM1   = CW1'(TILE_H - 1);
  localparam logic [COORD_W-1:0] TileWStep = COORD_W'(TILE_W);
  localparam logic [COORD_W-1:0] TileHStep = COORD_W'(TILE_H);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] w_m1_q, w_m1_d, h_m1_q, h_m1_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d;  // current tile origin
  logic               tiled_q, tiled_d, cont_q, cont_d, done_q, done_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

  logic [COORD_W:0]   ex_sum, ey_sum;
  logic [COORD_W-1:0] ex, ey;
  logic               row_end, last_px, xfer;

  // Clipped tile bounds; sums carry one extra bit so origin+TILE-1 cannot wrap.
  always_comb begin
    ex_sum = {1'b0, ox_q} + TileWM1;
    ey_sum = {1'b0, oy_q} + TileHM1;
    ex     = (ex_sum > {1'b0, w_m1_q}) ? w_m1_q : ex_sum[COORD_W-1:0];
    ey     = (ey_sum > {1'b0, h_m1_q}) ? h_m1_q : ey_sum[COORD_W-1:0];
  end

  always_comb begin
    out_valid = (state_q == StRun);
    busy      = out_valid;
    pixel_x   = x_q;
    pixel_y   = y_q;
    row_end   = tiled_q ? (x_q == ex) : (x_q == w_m1_q);
    // Both traversal orders finish on the bottom-right pixel.
    last_px   = (x_q == w_m1_q) && (y_q == h_m1_q);
    sof       = out_valid && (x_q == '0) && (y_q == '0);
    eol       = out_valid && row_end;
    eof       = out_valid && last_px;
    done      = done_q;
    frame_cnt = fcnt_q;
    xfer      = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    w_m1_d  = w_m1_q;
    h_m1_d  = h_m1_q;
    tiled_d = tiled_q;
    cont_d  = cont_q;
    x_d     = x_q;
    y_d     = y_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort && (cfg_width != '0) && (cfg_height != '0)) begin
          state_d = StRun;
          w_m1_d  = cfg_width - COORD_W'(1);
          h_m1_d  = cfg_height - COORD_W'(1);
          tiled_d = cfg_tiled;
          cont_d  = cfg_continuous;
          x_d     = '0;
          y_d     = '0;
          ox_d    = '0;
          oy_d    = '0;
        end
      end
      StRun: begin
        if (abort) begin
          // Abort wins over a simultaneous transfer, even on the eof beat.
          state_d = StIdle;
          x_d     = '0;
          y_d     = '0;
          ox_d    = '0;
          oy_d    = '0;
        end else if (xfer) begin
          if (last_px) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
            x_d    = '0;
            y_d    = '0;
            ox_d   = '0;
            oy_d   = '0;
            if (!cont_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else if (!tiled_q) begin
            if (row_end) begin
              x_d = '0;
              y_d = y_q + COORD_W'(1);
            end else begin
              x_d = x_q + COORD_W'(1);
            end
          end else if (!row_end) begin
            x_d = x_q + COORD_W'(1);
          end else if (y_q != ey) begin
            x_d = ox_q;
            y_d = y_q + COORD_W'(1);
          end else if (ex != w_m1_q) begin
            // Next tile to the right; ex < W-1 so the new origin still fits.
            ox_d = ox_q + TileWStep;
            x_d  = ox_q + TileWStep;
            y_d  = oy_q;
          end else begin
            ox_d = '0;
            x_d  = '0;
            oy_d = oy_q + TileHStep;
            y_d  = oy_q + TileHStep;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      w_m1_q  <= '0;
      h_m1_q  <= '0;
      tiled_q <= 1'b0;
      cont_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      fcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_m1_q  <= w_m1_d;
      h_m1_q  <= h_m1_d;
      tiled_q <= tiled_d;
      cont_q  <= cont_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      fcnt_q  <= fcnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Self-checking bench for pixel_stream_gen (TILE_W = TILE_H = 2).
module tb_pixel_stream_gen;

  localparam int CW = 10;
  localparam int FW = 16;
  localparam int TW = 2;
  localparam int TH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_width, cfg_height;
  logic          cfg_tiled, cfg_continuous;
  logic          start, abort, out_ready;
  logic          out_valid, sof, eol, eof, busy, done;
  logic [CW-1:0] pixel_x, pixel_y;
  logic [FW-1:0] frame_cnt;

  int tests_run = 0;
  int fails     = 0;
  int exp_fcnt  = 0;

  // Expected beat sequence of one frame.
  int exp_x[$];
  int exp_y[$];
  bit exp_eol[$];

  always #5 clk = ~clk;

  pixel_stream_gen #(
    .COORD_W(CW),
    .TILE_W (TW),
    .TILE_H (TH),
    .FCNT_W (FW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .cfg_tiled     (cfg_tiled),
    .cfg_continuous(cfg_continuous),
    .start         (start),
    .abort         (abort),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .sof           (sof),
    .eol           (eol),
    .eof           (eof),
    .busy          (busy),
    .done          (done),
    .frame_cnt     (frame_cnt)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Reference traversal built directly from nested tile / pixel loops.
  task automatic build_expected(input int w, input int h, input bit tiled);
    exp_x.delete();
    exp_y.delete();
    exp_eol.delete();
    if (!tiled) begin
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          exp_x.push_back(x);
          exp_y.push_back(y);
          exp_eol.push_back(x == w - 1);
        end
    end else begin
      for (int ty = 0; ty < h; ty += TH)
        for (int tx = 0; tx < w; tx += TW)
          for (int y = ty; y < imin(ty + TH, h); y++)
            for (int x = tx; x < imin(tx + TW, w); x++) begin
              exp_x.push_back(x);
              exp_y.push_back(y);
              exp_eol.push_back(x == imin(tx + TW, w) - 1);
            end
    end
  endtask

  // Runs one single-shot frame, checking every cycle against the expected list.
  // noise: scribble start/cfg while running, which must be ignored.
  task automatic run_frame(input string name, input int w, input int h, input bit tiled,
                           input int ready_pct, input bit noise);
    int  n;
    int  idx;
    int  cyc;
    bit  rdy;
    build_expected(w, h, tiled);
    n              = exp_x.size();
    cfg_width      = CW'(w);
    cfg_height     = CW'(h);
    cfg_tiled      = tiled;
    cfg_continuous = 1'b0;
    out_ready      = 1'b0;
    start          = 1'b1;
    tick();
    start = 1'b0;
    idx   = 0;
    cyc   = 0;
    while (idx < n && cyc < 4000) begin
      tests_run++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || pixel_x !== CW'(exp_x[idx]) ||
          pixel_y !== CW'(exp_y[idx]) || sof !== (idx == 0) || eol !== exp_eol[idx] ||
          eof !== (idx == n - 1) || done !== 1'b0 || frame_cnt !== FW'(exp_fcnt)) begin
        fails++;
        $display("FAIL %s beat %0d: got v=%b busy=%b (%0d,%0d) sof=%b eol=%b eof=%b done=%b fcnt=%0d, want (%0d,%0d) sof=%b eol=%b eof=%b fcnt=%0d",
                 name, idx, out_valid, busy, pixel_x, pixel_y, sof, eol, eof, done,
                 frame_cnt, exp_x[idx], exp_y[idx], idx == 0, exp_eol[idx], idx == n - 1,
                 exp_fcnt);
      end
      rdy       = ($urandom_range(99) < ready_pct);
      out_ready = rdy;
      if (noise) begin
        cfg_width      = CW'($urandom_range(15));
        cfg_height     = CW'($urandom_range(15));
        cfg_tiled      = 1'($urandom_range(1));
        cfg_continuous = 1'($urandom_range(1));
        start          = (rdy && idx == n - 1) ? 1'b0 : 1'($urandom_range(1));
      end
      if (rdy) begin
        if (idx == n - 1) exp_fcnt++;
        idx++;
      end
      tick();
      cyc++;
    end
    start          = 1'b0;
    out_ready      = 1'b0;
    cfg_continuous = 1'b0;
    if (idx < n) begin
      fails++;
      $display("FAIL %s timeout: got %0d beats, want %0d", name, idx, n);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || frame_cnt !== FW'(exp_fcnt)) begin
      fails++;
      $display("FAIL %s completion: got v=%b busy=%b done=%b fcnt=%0d, want v=0 busy=0 done=1 fcnt=%0d",
               name, out_valid, busy, done, frame_cnt, exp_fcnt);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s done_pulse: got done=%b v=%b busy=%b, want 0 0 0", name, done, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cfg_width = 10'd4; cfg_height = 10'd3; cfg_tiled = 1'b0; cfg_continuous = 1'b0;
    start = 1'b1; abort = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({out_valid, pixel_x, pixel_y, sof, eol, eof, busy, done, frame_cnt} !== '0) begin
        fails++;
        $display("FAIL reset: got v=%b (%0d,%0d) sof=%b eol=%b eof=%b busy=%b done=%b fcnt=%0d, want all zero",
                 out_valid, pixel_x, pixel_y, sof, eol, eof, busy, done, frame_cnt);
      end
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    exp_fcnt = 0;
    tick();
  endtask

  task automatic test_raster();
    run_frame("raster_4x3", 4, 3, 1'b0, 100, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frame("bp_4x2", 4, 2, 1'b0, 50, 1'b0);
  endtask

  task automatic test_tiled();
    run_frame("tiled_3x3", 3, 3, 1'b1, 100, 1'b0);
    run_frame("tiled_1x1", 1, 1, 1'b1, 100, 1'b0);
    run_frame("tiled_5x4_bp", 5, 4, 1'b1, 60, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_frame("random", $urandom_range(1, 7), $urandom_range(1, 7), 1'($urandom_range(1)),
                $urandom_range(30, 100), 1'($urandom_range(1)));
    end
  endtask

  task automatic test_start_during_run();
    run_frame("start_in_run", 4, 3, 1'b0, 70, 1'b1);
  endtask

  task automatic test_continuous();
    cfg_width = 10'd2; cfg_height = 10'd2; cfg_tiled = 1'b0; cfg_continuous = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_continuous = 1'b0;
    for (int i = 0; i < 10; i++) begin
      int k;
      k = i % 4;
      tests_run++;
      if (out_valid !== 1'b1 || pixel_x !== CW'(k % 2) || pixel_y !== CW'(k / 2) ||
          sof !== (k == 0) || eol !== (k % 2 == 1) || eof !== (k == 3) || done !== 1'b0 ||
          frame_cnt !== FW'(exp_fcnt)) begin
        fails++;
        $display("FAIL continuous cycle %0d: got v=%b (%0d,%0d) sof=%b eol=%b eof=%b done=%b fcnt=%0d, want (%0d,%0d) sof=%b eol=%b eof=%b done=0 fcnt=%0d",
                 i, out_valid, pixel_x, pixel_y, sof, eol, eof, done, frame_cnt,
                 k % 2, k / 2, k == 0, k % 2 == 1, k == 3, exp_fcnt);
      end
      if (k == 3) exp_fcnt++;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || frame_cnt !== FW'(exp_fcnt)) begin
      fails++;
      $display("FAIL continuous_abort: got v=%b busy=%b done=%b fcnt=%0d, want 0 0 0 fcnt=%0d",
               out_valid, busy, done, frame_cnt, exp_fcnt);
    end
  endtask

  task automatic test_abort();
    cfg_width = 10'd4; cfg_height = 10'd3; cfg_tiled = 1'b0; cfg_continuous = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || pixel_x !== 10'd1 || pixel_y !== 10'd0) begin
      fails++;
      $display("FAIL abort_setup: got v=%b (%0d,%0d), want v=1 (1,0)", out_valid, pixel_x, pixel_y);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || frame_cnt !== FW'(exp_fcnt)) begin
      fails++;
      $display("FAIL abort_mid: got v=%b busy=%b done=%b fcnt=%0d, want 0 0 0 fcnt=%0d",
               out_valid, busy, done, frame_cnt, exp_fcnt);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_mid_after: got done=%b v=%b, want 0 0", done, out_valid);
    end
    // Abort on a 1x1 frame's eof beat: no count, no done.
    cfg_width = 10'd1; cfg_height = 10'd1;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || sof !== 1'b1 || eol !== 1'b1 || eof !== 1'b1) begin
      fails++;
      $display("FAIL one_px_markers: got v=%b sof=%b eol=%b eof=%b, want 1 1 1 1",
               out_valid, sof, eol, eof);
    end
    out_ready = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || done !== 1'b0 || frame_cnt !== FW'(exp_fcnt)) begin
      fails++;
      $display("FAIL abort_eof: got v=%b done=%b fcnt=%0d, want 0 0 fcnt=%0d",
               out_valid, done, frame_cnt, exp_fcnt);
    end
    tick();
    tests_run++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL abort_eof_after: got done=%b, want 0", done);
    end
  endtask

  task automatic test_bad_start();
    for (int i = 0; i < 3; i++) begin
      cfg_width  = (i == 0) ? 10'd0 : 10'd3;
      cfg_height = (i == 1) ? 10'd0 : 10'd3;
      abort      = (i == 2);
      start      = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL bad_start case %0d: got v=%b busy=%b, want 0 0", i, out_valid, busy);
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    cfg_width = 10'd4; cfg_height = 10'd3; cfg_tiled = 1'b0; cfg_continuous = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if ({out_valid, pixel_x, pixel_y, sof, eol, eof, busy, done, frame_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got v=%b (%0d,%0d) sof=%b eol=%b eof=%b busy=%b done=%b fcnt=%0d, want all zero",
               out_valid, pixel_x, pixel_y, sof, eol, eof, busy, done, frame_cnt);
    end
    rst = 1'b1;
    out_ready = 1'b0;
    exp_fcnt = 0;
    tick();
    run_frame("after_reset", 4, 3, 1'b0, 100, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_tiled = 1'b0; cfg_continuous = 1'b0;
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    test_reset();
    test_raster();
    test_backpressure();
    test_tiled();
    test_continuous();
    test_abort();
    test_bad_start();
    test_start_during_run();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
